// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine sequencer.
//   state_t       : sequencer states IDLE / COLLECT / VEND / CHANGE
//   CREDIT_W      : width of the credit register (rupees)
//   COIN_*        : coin values in rupees
//   coin_value()  : value of coin strobe index 0/1/2 (5/10/25)
//   price_lookup(): selects one of four product prices by index
package vend_pkg;

    localparam int CREDIT_W  = 8;
    localparam int NUM_COINS = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam logic [CREDIT_W-1:0] COIN_FIVE        = 8'd5;
    localparam logic [CREDIT_W-1:0] COIN_TEN         = 8'd10;
    localparam logic [CREDIT_W-1:0] COIN_TWENTY_FIVE = 8'd25;

    // Coin strobe bit order: 0 = five, 1 = ten, 2 = twenty-five.
    function automatic logic [CREDIT_W-1:0] coin_value(input int idx);
        case (idx)
            0:       return COIN_FIVE;
            1:       return COIN_TEN;
            default: return COIN_TWENTY_FIVE;
        endcase
    endfunction

    function automatic logic [CREDIT_W-1:0] price_lookup(
        input logic [1:0]          sel,
        input logic [CREDIT_W-1:0] p0,
        input logic [CREDIT_W-1:0] p1,
        input logic [CREDIT_W-1:0] p2,
        input logic [CREDIT_W-1:0] p3
    );
        case (sel)
            2'd0:    return p0;
            2'd1:    return p1;
            2'd2:    return p2;
            default: return p3;
        endcase
    endfunction

endpackage

// File: rtl/vend_if.sv
// Signal bundle between the vending sequencer and its surroundings
// (coin acceptor, keypad, dispenser, change ejector).
//   slave  : the sequencer side (consumes coins/selection/acks, drives requests)
//   master : the environment side
interface vend_if;
    import vend_pkg::*;

    logic                fiveRupees;
    logic                tenRupees;
    logic                twentyFiveRupees;
    logic [1:0]          productSel;
    logic                selValid;
    logic                cancel;
    logic                dispenseAck;
    logic                changeAck;
    logic                dispenseReq;
    logic                changeReq;
    logic                theProduct;
    logic                coinReject;
    logic                lowCredit;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport slave (
        input  fiveRupees, tenRupees, twentyFiveRupees, productSel, selValid,
               cancel, dispenseAck, changeAck,
        output dispenseReq, changeReq, theProduct, coinReject, lowCredit,
               credit, busy
    );

    modport master (
        output fiveRupees, tenRupees, twentyFiveRupees, productSel, selValid,
               cancel, dispenseAck, changeAck,
        input  dispenseReq, changeReq, theProduct, coinReject, lowCredit,
               credit, busy
    );

endinterface

// File: rtl/vend_credit_acc.sv
// Credit accumulator: decodes coin strobes, decides accept/reject and
// holds the credit register.
//   clock, reset  : clock, asynchronous active-low reset
//   coin_strobe   : {25, 10, 5} coin strobes
//   coin_window   : sequencer allows crediting this cycle
//   sub_en/sub_val: subtract request (price or one change coin)
//   credit        : current credit
//   coin_credit   : combinational, the coin this cycle is being credited
//   coin_reject   : registered one-cycle pulse for any coin not credited
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT = 50
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_COINS-1:0] coin_strobe,
    input  logic                 coin_window,
    input  logic                 sub_en,
    input  logic [CREDIT_W-1:0]  sub_val,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 coin_credit,
    output logic                 coin_reject
);

    logic [CREDIT_W-1:0] credit_reg;
    logic                coin_reject_reg;
    logic [CREDIT_W-1:0] coin_part [NUM_COINS];
    logic [CREDIT_W-1:0] coin_sum;
    logic [1:0]          coin_count;
    logic [CREDIT_W:0]   sum_wide;
    logic                coin_any;
    logic                coin_multi;
    logic                coin_over;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COINS; gi++) begin : g_coin
            assign coin_part[gi] = coin_strobe[gi] ? coin_value(gi) : '0;
        end
    endgenerate

    // The OR of values is only meaningful with a single strobe; multiple
    // strobes are rejected outright so the merged value is never used.
    always_comb begin
        coin_sum   = '0;
        coin_count = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            coin_sum   = coin_sum | coin_part[i];
            coin_count = coin_count + 2'(coin_strobe[i]);
        end
    end

    assign coin_any    = |coin_strobe;
    assign coin_multi  = coin_count > 2'd1;
    assign sum_wide    = {1'b0, credit_reg} + {1'b0, coin_sum};
    assign coin_over   = sum_wide > (CREDIT_W+1)'(MAX_CREDIT);
    assign coin_credit = coin_window & coin_any & ~coin_multi & ~coin_over;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credit_reg      <= '0;
            coin_reject_reg <= 1'b0;
        end else begin
            coin_reject_reg <= coin_any & ~coin_credit;
            if (coin_credit) begin
                credit_reg <= sum_wide[CREDIT_W-1:0];
            end else if (sub_en && (credit_reg >= sub_val)) begin
                credit_reg <= credit_reg - sub_val;
            end
        end
    end

    assign credit      = credit_reg;
    assign coin_reject = coin_reject_reg;

endmodule

// File: rtl/vend_sequencer.sv
// Vending-machine transaction sequencer: collects coin credit, checks a
// product selection against a four-entry price table, then drives the
// dispenser and the 5-rupee change ejector through req/ack handshakes.
//   clock, reset : clock, asynchronous active-low reset
//   bus          : vend_if.slave (coins, selection, cancel, acks in;
//                  dispenseReq, changeReq, theProduct, coinReject,
//                  lowCredit, credit, busy out)
// Optional: define VEND_TIMEOUT_EN to refund automatically after
// TIMEOUT_CYC idle cycles in COLLECT.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE0     = 15,
    parameter int PRICE1     = 20,
    parameter int PRICE2     = 25,
    parameter int PRICE3     = 30,
    parameter int MAX_CREDIT = 50
`ifdef VEND_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1000
`endif
) (
    input  logic clock,
    input  logic reset,
    vend_if.slave bus
);

    state_t              state_reg;
    logic                dispense_req_reg;
    logic                change_req_reg;
    logic                the_product_reg;
    logic                low_credit_reg;
    logic                busy_reg;

    logic [NUM_COINS-1:0] coin_strobe;
    logic [CREDIT_W-1:0]  credit;
    logic [CREDIT_W-1:0]  price;
    logic                 coin_credit;
    logic                 coin_reject;
    logic                 in_collect;
    logic                 any_event;
    logic                 timeout_hit;
    logic                 afford;
    logic                 cancel_take;
    logic                 sel_take;
    logic                 change_take;
    logic                 dispense_take;
    logic                 coin_window;
    logic                 low_credit_next;

    assign coin_strobe = {bus.twentyFiveRupees, bus.tenRupees, bus.fiveRupees};
    assign in_collect  = (state_reg == COLLECT);
    assign any_event   = (|coin_strobe) | bus.selValid | bus.cancel;

`ifdef VEND_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] idle_cnt_reg;

    // Counts quiet cycles in COLLECT; any customer activity restarts it.
    assign timeout_hit = in_collect & ~any_event &
                         (idle_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_cnt_reg <= '0;
        end else if (!in_collect || any_event || timeout_hit) begin
            idle_cnt_reg <= '0;
        end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign price = price_lookup(bus.productSel,
                                CREDIT_W'(PRICE0), CREDIT_W'(PRICE1),
                                CREDIT_W'(PRICE2), CREDIT_W'(PRICE3));
    assign afford = (credit >= price);

    // Cancel (or timeout) wins over selection and coins in the same cycle.
    assign cancel_take   = in_collect & (bus.cancel | timeout_hit);
    assign sel_take      = in_collect & bus.selValid & ~bus.cancel & afford;
    assign change_take   = (state_reg == CHANGE) & change_req_reg & bus.changeAck;
    assign dispense_take = (state_reg == VEND) & dispense_req_reg & bus.dispenseAck;
    assign coin_window   = ((state_reg == IDLE) | in_collect) & ~cancel_take & ~sel_take;
    assign low_credit_next = bus.selValid & ~cancel_take &
                             ((state_reg == IDLE) | (in_collect & ~afford));

    vend_credit_acc #(
        .MAX_CREDIT (MAX_CREDIT)
    ) u_credit (
        .clock       (clock),
        .reset       (reset),
        .coin_strobe (coin_strobe),
        .coin_window (coin_window),
        .sub_en      (sel_take | change_take),
        .sub_val     (sel_take ? price : COIN_FIVE),
        .credit      (credit),
        .coin_credit (coin_credit),
        .coin_reject (coin_reject)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            dispense_req_reg <= 1'b0;
            change_req_reg   <= 1'b0;
            the_product_reg  <= 1'b0;
            low_credit_reg   <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            the_product_reg <= 1'b0;
            low_credit_reg  <= low_credit_next;
            case (state_reg)
                IDLE: begin
                    if (coin_credit) begin
                        state_reg <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (cancel_take) begin
                        if (credit != '0) begin
                            state_reg      <= CHANGE;
                            change_req_reg <= 1'b1;
                            busy_reg       <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (sel_take) begin
                        state_reg        <= VEND;
                        dispense_req_reg <= 1'b1;
                        busy_reg         <= 1'b1;
                    end
                end
                VEND: begin
                    if (dispense_take) begin
                        dispense_req_reg <= 1'b0;
                        the_product_reg  <= 1'b1;
                        // credit already holds the post-price remainder
                        if (credit != '0) begin
                            state_reg      <= CHANGE;
                            change_req_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                CHANGE: begin
                    if (change_take && (credit <= COIN_FIVE)) begin
                        change_req_reg <= 1'b0;
                        state_reg      <= IDLE;
                        busy_reg       <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.dispenseReq = dispense_req_reg;
    assign bus.changeReq   = change_req_reg;
    assign bus.theProduct  = the_product_reg;
    assign bus.coinReject  = coin_reject;
    assign bus.lowCredit   = low_credit_reg;
    assign bus.credit      = credit;
    assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed testbench for vend_sequencer. Inputs change 1 time unit after
// the rising edge; outputs are checked at the same point, i.e. they show
// the effect of the edge just taken.
module tb_vend_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    vend_if bus ();

    vend_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic coin(input logic f, input logic t, input logic tf);
        bus.fiveRupees = f; bus.tenRupees = t; bus.twentyFiveRupees = tf;
        tick();
        bus.fiveRupees = 0; bus.tenRupees = 0; bus.twentyFiveRupees = 0;
    endtask

    task automatic select(input logic [1:0] p);
        bus.productSel = p; bus.selValid = 1;
        tick();
        bus.selValid = 0;
    endtask

    task automatic do_cancel();
        bus.cancel = 1;
        tick();
        bus.cancel = 0;
    endtask

    task automatic ack_dispense();
        bus.dispenseAck = 1;
        tick();
        bus.dispenseAck = 0;
    endtask

    task automatic ack_change();
        bus.changeAck = 1;
        tick();
        bus.changeAck = 0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            ack_change();
            tick();
        end
    endtask

    initial begin
        bus.fiveRupees = 0; bus.tenRupees = 0; bus.twentyFiveRupees = 0;
        bus.productSel = 0; bus.selValid = 0; bus.cancel = 0;
        bus.dispenseAck = 0; bus.changeAck = 0;

        // reset state
        repeat (3) tick();
        check_val("reset_credit", 32'(bus.credit), 0);
        check_val("reset_flags", 32'({bus.dispenseReq, bus.changeReq, bus.theProduct,
                                      bus.coinReject, bus.lowCredit, bus.busy}), 0);
        reset = 1;
        tick();

        // 10+10, product 1 (20): exact payment, no change
        coin(0, 1, 0);
        check_val("t1_credit_10", 32'(bus.credit), 10);
        coin(0, 1, 0);
        check_val("t1_credit_20", 32'(bus.credit), 20);
        select(1);
        check_val("t1_credit_after_sel", 32'(bus.credit), 0);
        check_val("t1_dispense_req", 32'(bus.dispenseReq), 1);
        check_val("t1_busy", 32'(bus.busy), 1);
        tick(); tick();
        check_val("t1_dispense_req_held", 32'(bus.dispenseReq), 1);
        ack_dispense();
        check_val("t1_product", 32'(bus.theProduct), 1);
        check_val("t1_dispense_req_drop", 32'(bus.dispenseReq), 0);
        check_val("t1_no_change_req", 32'(bus.changeReq), 0);
        check_val("t1_not_busy", 32'(bus.busy), 0);
        tick();
        check_val("t1_product_pulse_end", 32'(bus.theProduct), 0);

        // stray acks in IDLE are ignored
        bus.changeAck = 1; bus.dispenseAck = 1;
        tick();
        bus.changeAck = 0; bus.dispenseAck = 0;
        check_val("stray_ack_credit", 32'(bus.credit), 0);
        check_val("stray_ack_outs", 32'({bus.changeReq, bus.theProduct, bus.dispenseReq}), 0);

        // 25+10, product 0 (15): 20 change as four 5-rupee coins
        coin(0, 0, 1);
        coin(0, 1, 0);
        check_val("t2_credit_35", 32'(bus.credit), 35);
        select(0);
        check_val("t2_credit_after_sel", 32'(bus.credit), 20);
        check_val("t2_dispense_req", 32'(bus.dispenseReq), 1);
        ack_dispense();
        check_val("t2_product", 32'(bus.theProduct), 1);
        check_val("t2_change_req", 32'(bus.changeReq), 1);
        check_val("t2_busy", 32'(bus.busy), 1);
        coin(1, 0, 0);
        check_val("t2_coin_in_change_reject", 32'(bus.coinReject), 1);
        check_val("t2_coin_in_change_credit", 32'(bus.credit), 20);
        for (int i = 0; i < 4; i++) begin
            ack_change();
            check_val($sformatf("t2_change_credit_%0d", i), 32'(bus.credit), 32'(20 - 5 * (i + 1)));
            check_val($sformatf("t2_change_req_%0d", i), 32'(bus.changeReq), (i < 3) ? 1 : 0);
            tick();
        end
        check_val("t2_idle_not_busy", 32'(bus.busy), 0);

        // 25+25 reaches the ceiling; a further 5 is rejected
        coin(0, 0, 1);
        coin(0, 0, 1);
        check_val("t3_credit_50", 32'(bus.credit), 50);
        coin(1, 0, 0);
        check_val("t3_over_reject", 32'(bus.coinReject), 1);
        check_val("t3_credit_held", 32'(bus.credit), 50);
        tick();
        check_val("t3_reject_pulse_end", 32'(bus.coinReject), 0);
        do_cancel();
        check_val("t3_cancel_change_req", 32'(bus.changeReq), 1);
        drain(10);
        check_val("t3_refund_done", 32'({bus.credit, bus.changeReq}), 0);

        // two strobes in one cycle: nothing credited
        coin(1, 1, 0);
        check_val("t4_multi_reject", 32'(bus.coinReject), 1);
        check_val("t4_multi_credit", 32'(bus.credit), 0);
        select(0);
        check_val("t4_idle_low_credit", 32'(bus.lowCredit), 1);
        tick();
        check_val("t4_low_credit_end", 32'(bus.lowCredit), 0);

        // credit 10 cannot buy product 3; cancel beats selValid
        coin(0, 1, 0);
        select(3);
        check_val("t5_low_credit", 32'(bus.lowCredit), 1);
        check_val("t5_credit_kept", 32'(bus.credit), 10);
        check_val("t5_no_dispense", 32'(bus.dispenseReq), 0);
        bus.cancel = 1; bus.selValid = 1; bus.productSel = 0;
        tick();
        bus.cancel = 0; bus.selValid = 0;
        check_val("t5_cancel_change_req", 32'(bus.changeReq), 1);
        check_val("t5_cancel_no_low", 32'(bus.lowCredit), 0);
        check_val("t5_cancel_credit", 32'(bus.credit), 10);
        ack_change();
        check_val("t5_refund_1", 32'({bus.credit, bus.changeReq}), 32'({8'd5, 1'b1}));
        ack_change();
        check_val("t5_refund_2", 32'({bus.credit, bus.changeReq}), 0);
        tick();

        // coin together with an accepted selection is returned
        coin(0, 0, 1);
        bus.productSel = 2; bus.selValid = 1; bus.fiveRupees = 1;
        tick();
        bus.selValid = 0; bus.fiveRupees = 0;
        check_val("t6_sel_coin_reject", 32'(bus.coinReject), 1);
        check_val("t6_credit", 32'(bus.credit), 0);
        check_val("t6_dispense_req", 32'(bus.dispenseReq), 1);
        ack_dispense();
        check_val("t6_product", 32'({bus.theProduct, bus.busy}), 32'(2'b10));

        // reset in CHANGE clears everything at once
        coin(0, 1, 0);
        do_cancel();
        check_val("t7_change_before_reset", 32'(bus.changeReq), 1);
        reset = 0;
        #1;
        check_val("t7_reset_credit", 32'(bus.credit), 0);
        check_val("t7_reset_flags", 32'({bus.dispenseReq, bus.changeReq, bus.theProduct,
                                         bus.coinReject, bus.lowCredit, bus.busy}), 0);
        tick();
        reset = 1;
        tick();

`ifdef VEND_TIMEOUT_EN
        begin
            int waited = 0;
            coin(1, 0, 0);
            while (!bus.changeReq && waited < 1100) begin
                tick();
                waited++;
            end
            check_val("to_wait_cycles", 32'(waited), 1000);
            check_val("to_change_credit", 32'(bus.credit), 5);
            ack_change();
            check_val("to_refund_done", 32'({bus.credit, bus.changeReq, bus.busy}), 0);
        end
`else
        coin(1, 0, 0);
        repeat (1100) tick();
        check_val("no_to_still_waiting", 32'(bus.changeReq), 0);
        check_val("no_to_credit_held", 32'(bus.credit), 5);
        do_cancel();
        drain(1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
